cvm300_spi_responder: RTL and testbench
=======================================

// Module: cvm300_spi_responder
// PURPOSE
//  SPI responder (slave) end of the CVM300 sensor register bus, running in the clk domain.
//  Decodes 16-bit frames from the SPI master: R/W bit, 7-bit address, 8-bit data.
//  Holds a 128x8 register file: writes update it, reads return it on MISO.
//  Serves as the sensor stand-in for closed-loop bring-up, and as a fabric-side register bank.
// PARAMETERS
//  SYNC_STAGES  2     input synchronizer depth on SPI_CLK/SPI_EN/SPI_MOSI (>=2)
//  RO_BASE      7'h70 first read-only address (used only with SPI_RESP_RO_EN)
// PORTS
//  clk          in   1  system clock; SPI_CLK must be <= clk/8
//  rst_n        in   1  asynchronous active-low reset
//  SPI_EN       in   1  frame enable, active high
//  SPI_CLK      in   1  serial clock, CPOL=0
//  SPI_MOSI     in   1  master->responder data, MSB first
//  SPI_MISO     out  1  responder->master data
//  SPI_MISO_OE  out  1  MISO output enable (top level tristates on 0)
//  wr_valid     out  1  1-cycle pulse: register write committed
//  wr_addr      out  7  address of committed write
//  wr_data      out  8  data of committed write
//  frame_err    out  1  1-cycle pulse: frame aborted (SPI_EN fell before 16 bits)
//  lcl_addr     in   7  fabric-side read address
//  lcl_data     out  8  reg[lcl_addr], registered, 1-cycle latency
// BEHAVIOUR
//  - Reset: all 128 regs=8'h00, SPI_MISO=0, SPI_MISO_OE=0, wr_valid=0, wr_addr=0,
//    wr_data=0, frame_err=0, lcl_data=0, state=IDLE, bit counter=0.
//  - SPI inputs pass SYNC_STAGES flops; rise/fall of synced SPI_CLK are detected by
//    comparing with a further delayed copy. All edge actions apply SYNC_STAGES+1 cycles late.
//  - Frame bit order: b15=R/W (1=write, 0=read), b14..b8=addr, b7..b0=data; MOSI is
//    sampled on SPI_CLK rise, MISO changes on SPI_CLK fall.
//  - FSM: IDLE -> HDR on SPI_EN rise. HDR: shift 8 bits. After the 8th rise -> DATA;
//    on a read, latch reg[addr] into tx shifter, assert SPI_MISO_OE.
//    DATA: writes shift 8 MOSI bits; reads put tx bit7..bit0 on MISO at falls 8..15.
//    After the 16th rise -> DONE; on a write, commit reg[addr]<=data and pulse wr_valid the
//    next cycle with wr_addr/wr_data. DONE ignores further edges until SPI_EN falls -> IDLE.
//  - SPI_EN fall in HDR/DATA: discard frame, no reg update, pulse frame_err, drop
//    SPI_MISO_OE, -> IDLE. SPI_EN fall in DONE: no error.
//  - SPI_MISO_OE deasserts the cycle SPI_EN-low is seen; SPI_MISO forced 0 when OE=0.
//  - Read of an address written by the previous frame returns the new value (commit
//    precedes next frame's 8th edge by construction).
//  - lcl_data reflects a commit one cycle after the commit; same-cycle commit/lcl read of
//    that address returns the old value.
//  - rst_n low mid-frame: immediate return to reset state; next frame starts only on a
//    fresh SPI_EN rise after rst_n deasserts (SPI_EN already high at release -> wait for
//    it to fall, then rise).
// CONFIGURATION
//  SPI_RESP_RO_EN defined: addresses >= RO_BASE are read-only; writes to them complete
//    normally on the bus but leave reg unchanged and produce no wr_valid. Reg RO_BASE
//    resets to 8'hC3 (ID byte); other RO regs reset to 8'h00.
//  SPI_RESP_RO_EN undefined: all 128 addresses writable; RO_BASE unused.
// TESTING
//  1 write 0x1_05_A5 (R/W=1, addr 5, data A5) -> wr_valid once, wr_addr=5, wr_data=A5; lcl_addr=5 -> A5.
//  2 after 1, read addr 5 -> MISO bits 8..15 = 1010_0101, OE high only from fall 8 to EN low.
//  3 drop SPI_EN after 11 bits of write to addr 6, data 3C -> frame_err once, reg6 stays 00, no wr_valid.
//  4 20-clock write frame to addr 7, data 5A -> bits 17..20 ignored, reg7=5A, one wr_valid.
//  5 assert rst_n low mid-read of addr 5 -> OE=0 immediately, reg5=00, next clean frame decodes.
//  6 SPI_RESP_RO_EN: write 0x7F to 0x70 -> no wr_valid, read 0x70 returns C3; write to 0x6F succeeds.

Source files
------------

// File: rtl/cvm300_spi_responder.sv
// ---------------------------------------------------------------------------
// cvm300_spi_responder
//
// Purpose:
//   SPI responder end of the CVM300 sensor register bus. It runs entirely in
//   the clk domain by oversampling SPI_CLK, SPI_EN and SPI_MOSI.
//   Each frame is 16 bits, sent MSB first:
//     - bit 15 is R/W (1 = write)
//     - bits 14..8 are the address
//     - bits 7..0 are the data
//   Writes update a 128x8 register file. Reads return the addressed register
//   on MISO during the data byte. The same register file is also readable
//   from the fabric through lcl_addr/lcl_data.
//
// Configuration:
//   SPI_RESP_RO_EN - when defined, addresses >= RO_BASE are read-only.
//                    Writes to them complete on the bus but leave the
//                    register unchanged and raise no wr_valid.
//                    Register RO_BASE resets to 8'hC3 (ID byte).
//
// Parameters:
//   SYNC_STAGES  input synchronizer depth (>= 2)
//   RO_BASE      first read-only address (SPI_RESP_RO_EN builds only)
//
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   SPI_EN               frame enable, active high
//   SPI_CLK              serial clock, CPOL=0, at most clk/8
//   SPI_MOSI             master->responder data, sampled on SPI_CLK rise
//   SPI_MISO             responder->master data, changes on SPI_CLK fall;
//                        forced to 0 when SPI_MISO_OE is low
//   SPI_MISO_OE          MISO output enable (top level tristates on 0)
//   wr_valid             1-cycle pulse, register write committed
//   wr_addr, wr_data     address/data of the last committed write
//   frame_err            1-cycle pulse, frame aborted before 16 bits
//   lcl_addr             fabric read address
//   lcl_data             reg[lcl_addr], registered, 1-cycle latency
// ---------------------------------------------------------------------------
module cvm300_spi_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] RO_BASE     = 7'h70
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SPI_EN,
    input  logic       SPI_CLK,
    input  logic       SPI_MOSI,
    output logic       SPI_MISO,
    output logic       SPI_MISO_OE,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_err,
    input  logic [6:0] lcl_addr,
    output logic [7:0] lcl_data
);

`ifdef SPI_RESP_RO_EN
    localparam bit RO_EN = 1'b1;
`else
    localparam bit RO_EN = 1'b0;
`endif

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [SYNC_STAGES-1:0] r_clkSync;
    logic [SYNC_STAGES-1:0] r_enSync;
    logic [SYNC_STAGES-1:0] r_mosiSync;
    logic                   r_clkDly;
    logic                   r_enDly;

    logic [1:0] r_state;
    logic [3:0] r_bitCnt;
    logic [7:0] r_shift;
    logic       r_rw;
    logic [6:0] r_addr;
    logic [7:0] r_tx;
    logic       r_miso;
    logic       r_oe;
    logic       r_wrValid;
    logic [6:0] r_wrAddr;
    logic [7:0] r_wrData;
    logic       r_frameErr;
    logic [7:0] r_lclData;
    logic [7:0] r_regs [128];

    logic       w_clk;
    logic       w_en;
    logic       w_mosi;
    logic       w_clkRise;
    logic       w_clkFall;
    logic       w_enRise;
    logic       w_enFall;
    logic [6:0] w_hdrAddr;
    logic [7:0] w_rxByte;
    logic       w_roHit;

    // The SPI_EN chain resets to 1. If SPI_EN is already high when reset is
    // released, no rise is seen, so a frame in flight is ignored until the
    // master lowers and re-raises SPI_EN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clkSync  <= '0;
            r_enSync   <= '1;
            r_mosiSync <= '0;
            r_clkDly   <= 1'b0;
            r_enDly    <= 1'b1;
        end else begin
            r_clkSync  <= {r_clkSync[SYNC_STAGES-2:0], SPI_CLK};
            r_enSync   <= {r_enSync[SYNC_STAGES-2:0], SPI_EN};
            r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], SPI_MOSI};
            r_clkDly   <= w_clk;
            r_enDly    <= w_en;
        end
    end

    assign w_clk     = r_clkSync[SYNC_STAGES-1];
    assign w_en      = r_enSync[SYNC_STAGES-1];
    assign w_mosi    = r_mosiSync[SYNC_STAGES-1];
    assign w_clkRise = w_clk & ~r_clkDly;
    assign w_clkFall = ~w_clk & r_clkDly;
    assign w_enRise  = w_en & ~r_enDly;
    assign w_enFall  = ~w_en & r_enDly;

    // The byte being completed by the current rise: seven bits already
    // shifted in plus the incoming MOSI bit.
    assign w_rxByte  = {r_shift[6:0], w_mosi};
    assign w_hdrAddr = w_rxByte[6:0];
    assign w_roHit   = RO_EN && (r_addr >= RO_BASE);

    // Frame sequencer, register file and output registers.
    // The header is decoded on the 8th rise. The read byte is loaded into
    // r_tx at that point and shifted out on the following eight falls.
    // A write commits on the 16th rise. An SPI_EN fall before that point
    // discards the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_bitCnt   <= 4'd0;
            r_shift    <= 8'h00;
            r_rw       <= 1'b0;
            r_addr     <= 7'h00;
            r_tx       <= 8'h00;
            r_miso     <= 1'b0;
            r_oe       <= 1'b0;
            r_wrValid  <= 1'b0;
            r_wrAddr   <= 7'h00;
            r_wrData   <= 8'h00;
            r_frameErr <= 1'b0;
            for (int i = 0; i < 128; i++) begin
                r_regs[i] <= (RO_EN && (7'(i) == RO_BASE)) ? 8'hC3 : 8'h00;
            end
        end else begin
            r_wrValid  <= 1'b0;
            r_frameErr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_enRise) begin
                        r_state  <= ST_HDR;
                        r_bitCnt <= 4'd0;
                        r_shift  <= 8'h00;
                        r_miso   <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (w_enFall) begin
                        r_frameErr <= 1'b1;
                        r_oe       <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else if (w_clkRise) begin
                        r_shift  <= w_rxByte;
                        r_bitCnt <= r_bitCnt + 4'd1;
                        if (r_bitCnt == 4'd7) begin
                            r_state <= ST_DATA;
                            r_rw    <= w_rxByte[7];
                            r_addr  <= w_hdrAddr;
                            if (!w_rxByte[7]) begin
                                r_tx <= r_regs[w_hdrAddr];
                                r_oe <= 1'b1;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (w_enFall) begin
                        r_frameErr <= 1'b1;
                        r_oe       <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else if (w_clkRise) begin
                        r_shift  <= w_rxByte;
                        r_bitCnt <= r_bitCnt + 4'd1;
                        if (r_bitCnt == 4'd15) begin
                            r_state <= ST_DONE;
                            if (r_rw && !w_roHit) begin
                                r_regs[r_addr] <= w_rxByte;
                                r_wrValid      <= 1'b1;
                                r_wrAddr       <= r_addr;
                                r_wrData       <= w_rxByte;
                            end
                        end
                    end else if (w_clkFall && !r_rw) begin
                        r_miso <= r_tx[7];
                        r_tx   <= {r_tx[6:0], 1'b0};
                    end
                end
                default: begin
                    if (w_enFall) begin
                        r_oe    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Fabric read port. A commit in the same cycle is seen one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lclData <= 8'h00;
        end else begin
            r_lclData <= r_regs[lcl_addr];
        end
    end

    assign SPI_MISO    = r_miso & r_oe;
    assign SPI_MISO_OE = r_oe;
    assign wr_valid    = r_wrValid;
    assign wr_addr     = r_wrAddr;
    assign wr_data     = r_wrData;
    assign frame_err   = r_frameErr;
    assign lcl_data    = r_lclData;

endmodule

// File: tb/tb_cvm300_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_cvm300_spi_responder
//
// Self-checking bench for cvm300_spi_responder.
// It has three parts:
//   - a table of directed frames
//   - a hand-written mid-frame reset sequence
//   - randomized frames checked against a register-array model
// The bench honours SPI_RESP_RO_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_cvm300_spi_responder;

`ifdef SPI_RESP_RO_EN
    localparam bit RO = 1'b1;
`else
    localparam bit RO = 1'b0;
`endif
    localparam int         HALF    = 8;
    localparam logic [6:0] RO_ADDR = 7'h70;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SPI_EN;
    logic       SPI_CLK;
    logic       SPI_MOSI;
    logic       SPI_MISO;
    logic       SPI_MISO_OE;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err;
    logic [6:0] lcl_addr;
    logic [7:0] lcl_data;

    int         testsRun    = 0;
    int         testsFailed = 0;
    int         wrCnt       = 0;
    int         errCnt      = 0;
    logic [6:0] lastWrAddr  = 7'h00;
    logic [7:0] lastWrData  = 8'h00;
    logic [7:0] mem [128];

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
        int         nbits;
        int         expWr;
        int         expErr;
        logic [7:0] expRd;
    } vecT;

    vecT vecs[$];

    cvm300_spi_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .SPI_EN      (SPI_EN),
        .SPI_CLK     (SPI_CLK),
        .SPI_MOSI    (SPI_MOSI),
        .SPI_MISO    (SPI_MISO),
        .SPI_MISO_OE (SPI_MISO_OE),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_err   (frame_err),
        .lcl_addr    (lcl_addr),
        .lcl_data    (lcl_data)
    );

    always #5 clk = ~clk;

    // Counts committed writes and aborted frames, and keeps the last write.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_valid) begin
                wrCnt      = wrCnt + 1;
                lastWrAddr = wr_addr;
                lastWrData = wr_data;
            end
            if (frame_err) begin
                errCnt = errCnt + 1;
            end
        end
    end

    // Guards against a hung simulation.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation still running at 5ms, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model reset: every register is zero except the ID byte in RO builds.
    task automatic modelReset();
        for (int i = 0; i < 128; i++) begin
            mem[i] = (RO && (7'(i) == RO_ADDR)) ? 8'hC3 : 8'h00;
        end
    endtask

    function automatic bit writable(input logic [6:0] addr);
        return !RO || (addr < RO_ADDR);
    endfunction

    task automatic checkLcl(input string name, input logic [6:0] addr, input logic [7:0] exp);
        lcl_addr = addr;
        waitClk(2);
        checkOutput(name, int'(lcl_data), int'(exp));
    endtask

    // One SPI clock period. Returns MISO/OE as seen just before the rise,
    // which is when the master samples MISO.
    task automatic spiBit(input logic b, output logic misoS, output logic oeS);
        SPI_MOSI = b;
        waitClk(HALF);
        misoS   = SPI_MISO;
        oeS     = SPI_MISO_OE;
        SPI_CLK = 1'b1;
        waitClk(HALF);
        SPI_CLK = 1'b0;
    endtask

    // Sends one frame of nbits bits. Bits beyond 16 are random filler.
    // Also counts OE/MISO violations: OE must be high only during the data
    // byte of a read, and MISO must be 0 whenever OE is low.
    task automatic applyStimulus(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                                 input int nbits, output logic [7:0] rdByte, output int oeErrs,
                                 output int wrDelta, output int errDelta);
        logic [15:0] word;
        logic        m;
        logic        o;
        logic        b;
        logic        expOe;
        int          wr0;
        int          er0;
        word     = {rw, addr, data};
        wr0      = wrCnt;
        er0      = errCnt;
        oeErrs   = 0;
        rdByte   = 8'h00;
        SPI_CLK  = 1'b0;
        SPI_EN   = 1'b1;
        waitClk(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (i < 16) b = word[15-i];
            else        b = 1'($urandom_range(0, 1));
            spiBit(b, m, o);
            expOe = !rw && (i >= 8);
            if (o !== expOe) oeErrs++;
            if (!o && (m !== 1'b0)) oeErrs++;
            if (i >= 8 && i < 16) rdByte[15-i] = m;
        end
        waitClk(HALF);
        SPI_EN = 1'b0;
        waitClk(8);
        if (SPI_MISO_OE !== 1'b0) oeErrs++;
        wrDelta  = wrCnt - wr0;
        errDelta = errCnt - er0;
    endtask

    // Compares one frame's results with the expectations, then applies the
    // frame's effect to the model.
    task automatic runFrame(input string tag, input logic rw, input logic [6:0] addr,
                            input logic [7:0] data, input int nbits, input int expWr,
                            input int expErr, input logic [7:0] expRd);
        logic [7:0] rd;
        int         oeErrs;
        int         wrD;
        int         erD;
        applyStimulus(rw, addr, data, nbits, rd, oeErrs, wrD, erD);
        checkOutput({tag, " wr_valid count"}, wrD, expWr);
        checkOutput({tag, " frame_err count"}, erD, expErr);
        checkOutput({tag, " OE/MISO violations"}, oeErrs, 0);
        if (expWr == 1) begin
            checkOutput({tag, " wr_addr"}, int'(lastWrAddr), int'(addr));
            checkOutput({tag, " wr_data"}, int'(lastWrData), int'(data));
        end
        if (!rw && nbits >= 16) begin
            checkOutput({tag, " read data"}, int'(rd), int'(expRd));
        end
        if (rw && nbits >= 16 && writable(addr)) mem[addr] = data;
    endtask

    initial begin
        logic        m;
        logic        o;
        logic [15:0] word;
        int          wr0;
        int          er0;

        rst_n    = 1'b0;
        SPI_EN   = 1'b0;
        SPI_CLK  = 1'b0;
        SPI_MOSI = 1'b0;
        lcl_addr = 7'h00;
        modelReset();
        waitClk(4);

        // Values held during reset.
        checkOutput("reset MISO_OE", int'(SPI_MISO_OE), 0);
        checkOutput("reset MISO", int'(SPI_MISO), 0);
        checkOutput("reset wr_valid", int'(wr_valid), 0);
        checkOutput("reset wr_addr", int'(wr_addr), 0);
        checkOutput("reset wr_data", int'(wr_data), 0);
        checkOutput("reset frame_err", int'(frame_err), 0);
        checkOutput("reset lcl_data", int'(lcl_data), 0);
        rst_n = 1'b1;
        waitClk(4);
        checkLcl("reset reg5", 7'h05, 8'h00);
        checkLcl("reset reg70", RO_ADDR, RO ? 8'hC3 : 8'h00);

        // Directed frames: {rw, addr, data, nbits, expWr, expErr, expRd}.
        vecs.push_back('{1'b1, 7'h05, 8'hA5, 16, 1, 0, 8'h00});
        vecs.push_back('{1'b0, 7'h05, 8'h00, 16, 0, 0, 8'hA5});
        vecs.push_back('{1'b1, 7'h06, 8'h3C, 11, 0, 1, 8'h00});
        vecs.push_back('{1'b0, 7'h06, 8'h00, 16, 0, 0, 8'h00});
        vecs.push_back('{1'b1, 7'h07, 8'h5A, 20, 1, 0, 8'h00});
        vecs.push_back('{1'b0, 7'h07, 8'h00, 16, 0, 0, 8'h5A});
        vecs.push_back('{1'b0, 7'h05, 8'h00, 5, 0, 1, 8'h00});
        vecs.push_back('{1'b1, 7'h6F, 8'h11, 16, 1, 0, 8'h00});
        vecs.push_back('{1'b0, 7'h6F, 8'h00, 16, 0, 0, 8'h11});
        if (RO) begin
            vecs.push_back('{1'b1, 7'h70, 8'h7F, 16, 0, 0, 8'h00});
            vecs.push_back('{1'b0, 7'h70, 8'h00, 16, 0, 0, 8'hC3});
        end else begin
            vecs.push_back('{1'b1, 7'h70, 8'h7F, 16, 1, 0, 8'h00});
            vecs.push_back('{1'b0, 7'h70, 8'h00, 16, 0, 0, 8'h7F});
        end
        for (int k = 0; k < vecs.size(); k++) begin
            runFrame($sformatf("vec%0d", k), vecs[k].rw, vecs[k].addr, vecs[k].data,
                     vecs[k].nbits, vecs[k].expWr, vecs[k].expErr, vecs[k].expRd);
        end
        checkLcl("lcl reg5", 7'h05, 8'hA5);
        checkLcl("lcl reg6", 7'h06, 8'h00);
        checkLcl("lcl reg7", 7'h07, 8'h5A);

        // Reset during a read of address 5, released while SPI_EN is still
        // high. The rest of that frame, even a valid write, must be ignored.
        word    = 16'h0500;
        SPI_CLK = 1'b0;
        SPI_EN  = 1'b1;
        waitClk(HALF);
        for (int i = 0; i < 10; i++) spiBit(word[15-i], m, o);
        checkOutput("pre-reset OE", int'(SPI_MISO_OE), 1);
        wr0   = wrCnt;
        er0   = errCnt;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset OE", int'(SPI_MISO_OE), 0);
        checkOutput("midreset MISO", int'(SPI_MISO), 0);
        waitClk(3);
        rst_n = 1'b1;
        modelReset();
        word = 16'h8977;
        for (int i = 0; i < 16; i++) spiBit(word[15-i], m, o);
        checkOutput("post-reset stale OE", int'(SPI_MISO_OE), 0);
        waitClk(HALF);
        SPI_EN = 1'b0;
        waitClk(8);
        checkOutput("post-reset stale wr", wrCnt - wr0, 0);
        checkOutput("post-reset stale err", errCnt - er0, 0);
        checkLcl("post-reset reg5", 7'h05, 8'h00);
        checkLcl("post-reset reg9", 7'h09, 8'h00);
        runFrame("post-reset write", 1'b1, 7'h09, 8'h77, 16, 1, 0, 8'h00);
        runFrame("post-reset read", 1'b0, 7'h09, 8'h00, 16, 0, 0, 8'h77);

        // Random frames checked against the model array.
        for (int k = 0; k < 30; k++) begin
            logic       rw;
            logic [6:0] addr;
            logic [7:0] data;
            int         nbits;
            int         sel;
            int         expWr;
            rw   = 1'($urandom_range(0, 1));
            data = 8'($urandom);
            sel  = int'($urandom_range(0, 3));
            if (sel == 0)      addr = 7'($urandom_range(0, 7));
            else if (sel == 1) addr = 7'($urandom_range(16'h6E, 16'h71));
            else               addr = 7'($urandom_range(0, 127));
            sel = int'($urandom_range(0, 9));
            if (sel < 6)      nbits = 16;
            else if (sel < 8) nbits = 16 + int'($urandom_range(1, 4));
            else              nbits = int'($urandom_range(1, 15));
            expWr = (rw && nbits >= 16 && writable(addr)) ? 1 : 0;
            runFrame($sformatf("rand%0d", k), rw, addr, data, nbits, expWr,
                     (nbits < 16) ? 1 : 0, mem[addr]);
            checkLcl($sformatf("rand%0d lcl", k), addr, mem[addr]);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
